// File: rtl/mast_pkg.sv
// mast_pkg: FSM width, state codes and default index widths
// shared by the tile scheduler and the instruction fetcher.
package mast_pkg;

    localparam int MAST_FSM_BITS = 3;
    localparam int TILE_W        = 10;
    localparam int ROW_W         = 10;

    typedef enum logic [MAST_FSM_BITS-1:0] {
        M_IDLE = 3'd0,
        LEFT   = 3'd1,
        BASE   = 3'd2,
        RIGHT  = 3'd3,
        FSLD   = 3'd7
    } mast_state_e;

endpackage

// File: rtl/mast_tile_sched_if.sv
// mast_tile_sched_if: start/cfg/done inputs and load/compute controls of the tile scheduler.
// Ports: master = scheduler side, slave = fetcher/datapath side.
interface mast_tile_sched_if
    import mast_pkg::*;
#(
    parameter int TW = mast_pkg::TILE_W,
    parameter int RW = mast_pkg::ROW_W
) ();

    logic                     start_reg;
    logic [TW-1:0]            cfg_tile_num;
    logic [RW-1:0]            cfg_row_num;
    logic                     ld_done;
    logic                     cp_done;
    logic [MAST_FSM_BITS-1:0] mast_curr_state;
    logic                     ld_start;
    logic                     ld_sram_sel;
    logic                     cp_start;
    logic                     cp_sram_sel;
    logic                     pad_lf;
    logic                     pad_rg;
    logic [TW-1:0]            tile_idx;
    logic [RW-1:0]            row_idx;
    logic                     busy;
    logic                     sched_done;

    modport master (
        input  start_reg, cfg_tile_num, cfg_row_num, ld_done, cp_done,
        output mast_curr_state, ld_start, ld_sram_sel, cp_start, cp_sram_sel,
        output pad_lf, pad_rg, tile_idx, row_idx, busy, sched_done
    );

    modport slave (
        output start_reg, cfg_tile_num, cfg_row_num, ld_done, cp_done,
        input  mast_curr_state, ld_start, ld_sram_sel, cp_start, cp_sram_sel,
        input  pad_lf, pad_rg, tile_idx, row_idx, busy, sched_done
    );

endinterface

// File: rtl/mast_hs_track.sv
// mast_hs_track: sticky "done seen" flag for one start/done handshake.
// Ports: arm_i clears/presets on state entry, pulse_i done pulse, hit_o seen-or-now.
module mast_hs_track (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arm_i,
    input  logic pulse_i,
    input  logic preset_i,
    output logic hit_o
);

    logic seen_q, seen_d;

    // A pulse in the arm (start) cycle is dropped.
    always_comb begin
        seen_d = seen_q | pulse_i;
        if (arm_i) seen_d = preset_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) seen_q <= 1'b0;
        else       seen_q <= seen_d;
    end

    assign hit_o = ~arm_i & (seen_q | pulse_i);

endmodule

// File: rtl/mast_tile_sched.sv
// mast_tile_sched: walks FSLD then LEFT/BASE/RIGHT per column tile, row by row,
// issuing compute starts and ping-pong prefetch loads. Ports: clk, reset, bus (master).
module mast_tile_sched
    import mast_pkg::*;
#(
    parameter int TILE_W = mast_pkg::TILE_W,
    parameter int ROW_W  = mast_pkg::ROW_W
) (
    input logic               clk,
    input logic               reset,
    mast_tile_sched_if.master bus
);

    mast_state_e       state_q, state_d;
    logic [TILE_W-1:0] tnum_q, tnum_d, tile_q, tile_d, nt;
    logic [ROW_W-1:0]  rnum_q, rnum_d, row_q, row_d, nr;
    logic first_q, first_d, ld_start_q, ld_start_d, cp_start_q, cp_start_d;
    logic ld_sel_q, ld_sel_d, cp_sel_q, cp_sel_d;
    logic pad_lf_q, pad_lf_d, pad_rg_q, pad_rg_d;
    logic busy_q, busy_d, done_q, done_d;
    logic ld_hit, cp_hit, tile_st, accept, fsld_done, tile_done;
    logic last_col, last_row, sched_end, enter;

    mast_hs_track u_ld (
        .clk_i(clk), .rst_i(reset), .arm_i(first_q),
        .pulse_i(bus.ld_done), .preset_i(~ld_start_q), .hit_o(ld_hit)
    );

    mast_hs_track u_cp (
        .clk_i(clk), .rst_i(reset), .arm_i(first_q),
        .pulse_i(bus.cp_done), .preset_i(1'b0), .hit_o(cp_hit)
    );

    assign tile_st   = state_q inside {LEFT, BASE, RIGHT};
    assign accept    = (state_q == M_IDLE) && bus.start_reg &&
                       (bus.cfg_tile_num != '0) && (bus.cfg_row_num != '0);
    assign fsld_done = (state_q == FSLD) && ld_hit;
    assign tile_done = tile_st && ld_hit && cp_hit;
    assign last_col  = tile_q == tnum_q - TILE_W'(1);
    assign last_row  = row_q == rnum_q - ROW_W'(1);
    assign sched_end = tile_done && last_col && last_row;
    assign enter     = fsld_done || (tile_done && !sched_end);

    // Coordinates of the tile being entered (FSLD enters tile 0 of row 0).
    assign nt = (tile_st && !last_col) ? tile_q + TILE_W'(1) : '0;
    assign nr = (tile_st && last_col) ? row_q + ROW_W'(1) : row_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= M_IDLE;
            tnum_q     <= '0;
            rnum_q     <= '0;
            tile_q     <= '0;
            row_q      <= '0;
            first_q    <= 1'b0;
            ld_start_q <= 1'b0;
            cp_start_q <= 1'b0;
            ld_sel_q   <= 1'b0;
            cp_sel_q   <= 1'b0;
            pad_lf_q   <= 1'b0;
            pad_rg_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tnum_q     <= tnum_d;
            rnum_q     <= rnum_d;
            tile_q     <= tile_d;
            row_q      <= row_d;
            first_q    <= first_d;
            ld_start_q <= ld_start_d;
            cp_start_q <= cp_start_d;
            ld_sel_q   <= ld_sel_d;
            cp_sel_q   <= cp_sel_d;
            pad_lf_q   <= pad_lf_d;
            pad_rg_q   <= pad_rg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            accept:    state_d = FSLD;
            sched_end: state_d = M_IDLE;
            enter: begin
                if (nt == '0)                      state_d = LEFT;
                else if (nt == tnum_q - TILE_W'(1)) state_d = RIGHT;
                else                                state_d = BASE;
            end
            default: ;
        endcase
    end

    always_comb begin
        tnum_d     = tnum_q;
        rnum_d     = rnum_q;
        tile_d     = tile_q;
        row_d      = row_q;
        first_d    = 1'b0;
        ld_start_d = 1'b0;
        cp_start_d = 1'b0;
        ld_sel_d   = ld_sel_q;
        cp_sel_d   = cp_sel_q;
        pad_lf_d   = pad_lf_q;
        pad_rg_d   = pad_rg_q;
        done_d     = 1'b0;
        busy_d     = state_d != M_IDLE;
        unique case (1'b1)
            accept: begin
                tnum_d     = bus.cfg_tile_num;
                rnum_d     = bus.cfg_row_num;
                tile_d     = '0;
                row_d      = '0;
                first_d    = 1'b1;
                ld_start_d = 1'b1;
                ld_sel_d   = 1'b0;
                cp_sel_d   = 1'b0;
                pad_lf_d   = 1'b0;
                pad_rg_d   = 1'b0;
            end
            sched_end: begin
                done_d   = 1'b1;
                tile_d   = '0;
                row_d    = row_q + ROW_W'(1);
                cp_sel_d = ~cp_sel_q;
                pad_lf_d = 1'b0;
                pad_rg_d = 1'b0;
            end
            enter: begin
                tile_d     = nt;
                row_d      = nr;
                first_d    = 1'b1;
                cp_start_d = 1'b1;
                cp_sel_d   = tile_st ? ~cp_sel_q : cp_sel_q;
                // Prefetch the following tile unless this is the very last one.
                ld_start_d = !((nt == tnum_q - TILE_W'(1)) &&
                               (nr == rnum_q - ROW_W'(1)));
                ld_sel_d   = ld_start_d ? ~cp_sel_d : ld_sel_q;
                pad_lf_d   = nt == '0;
                pad_rg_d   = nt == tnum_q - TILE_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.mast_curr_state = state_q;
    assign bus.ld_start        = ld_start_q;
    assign bus.ld_sram_sel     = ld_sel_q;
    assign bus.cp_start        = cp_start_q;
    assign bus.cp_sram_sel     = cp_sel_q;
    assign bus.pad_lf          = pad_lf_q;
    assign bus.pad_rg          = pad_rg_q;
    assign bus.tile_idx        = tile_q;
    assign bus.row_idx         = row_q;
    assign bus.busy            = busy_q;
    assign bus.sched_done      = done_q;

endmodule

// File: tb/tb_mast_tile_sched.sv
// tb_mast_tile_sched: schedule-level reference checks of mast_tile_sched
// (tile order, states, pads, ping-pong selects, handshake timing, reset/ignore cases).
module tb_mast_tile_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mast_tile_sched_if #(.TW(10), .RW(10)) bus ();

    mast_tile_sched #(.TILE_W(10), .ROW_W(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int t;
        int r;
        int mode;
        int abort_k;
        bit mut;
        int exp_cp;
        int exp_ld;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dly(input int mode, input bit is_ld);
        case (mode)
            1:       return is_ld ? 3 : 1;
            2:       return is_ld ? 1 : 3;
            3:       return 2;
            4:       return is_ld ? 3 : 2;
            default: return int'($urandom_range(1, 4));
        endcase
    endfunction

    task automatic run(input vec_t v);
        int nt = v.t * v.r;
        int budget = nt * 12 + 40;
        int cyc = 0, n_cp = 0, n_ld = 0, n_done = 0;
        int exp_cp = -1, exp_done = -1, ld_at = -1, cp_at = -1;
        int t, r;
        bit got_ld = 0, got_cp = 0, cmpl = 0, fin = 0, abt = 0;
        bus.cfg_tile_num = 10'(v.t);
        bus.cfg_row_num  = 10'(v.r);
        bus.start_reg    = 1'b1;
        while (!fin && cyc < budget) begin
            tick();
            cyc++;
            bus.start_reg = v.mut && cyc == 5;
            if (v.mut) bus.cfg_tile_num = 10'd9;
            bus.ld_done = 1'b0;
            bus.cp_done = 1'b0;
            if (cyc == 1) begin
                check("fsld_state", int'(bus.mast_curr_state), 7);
                check("fsld_busy", int'(bus.busy), 1);
            end
            if (bus.ld_start) begin
                check("ld_sel", int'(bus.ld_sram_sel), n_ld % 2);
                n_ld++;
                ld_at = cyc + dly(v.mode, 1'b1);
            end
            if (cyc == exp_cp && n_cp < nt)
                check("cp_start_due", int'(bus.cp_start), 1);
            if (bus.cp_start) begin
                t = n_cp % v.t;
                r = n_cp / v.t;
                check("cp_cyc", cyc, exp_cp);
                check("tile_state", int'(bus.mast_curr_state),
                      t == 0 ? 1 : (t == v.t - 1 ? 3 : 2));
                check("pad_lf", int'(bus.pad_lf), int'(t == 0));
                check("pad_rg", int'(bus.pad_rg), int'(t == v.t - 1));
                check("tile_idx", int'(bus.tile_idx), t);
                check("row_idx", int'(bus.row_idx), r);
                check("cp_sel", int'(bus.cp_sram_sel), n_cp % 2);
                check("prefetch", int'(bus.ld_start), int'(n_cp != nt - 1));
                got_ld = (n_cp == nt - 1);
                got_cp = 1'b0;
                cmpl   = 1'b0;
                n_cp++;
                cp_at = cyc + dly(v.mode, 1'b0);
                if (n_cp - 1 == v.abort_k) begin
                    reset = 1'b1;
                    abt   = 1'b1;
                    fin   = 1'b1;
                end
            end
            if (bus.sched_done) begin
                n_done++;
                check("done_cyc", cyc, exp_done);
                check("done_state", int'(bus.mast_curr_state), 0);
                check("done_busy", int'(bus.busy), 0);
                fin = 1'b1;
            end
            if (!abt && cyc == ld_at) begin
                bus.ld_done = 1'b1;
                if (n_cp == 0) exp_cp = cyc + 1;
                else           got_ld = 1'b1;
            end
            if (!abt && cyc == cp_at) begin
                bus.cp_done = 1'b1;
                got_cp = 1'b1;
            end
            if (n_cp > 0 && got_ld && got_cp && !cmpl) begin
                cmpl = 1'b1;
                if (n_cp == nt) exp_done = cyc + 1;
                else            exp_cp = cyc + 1;
            end
        end
        if (abt) begin
            tick();
            check("rst_state", int'(bus.mast_curr_state), 0);
            check("rst_tile", int'(bus.tile_idx), 0);
            check("rst_row", int'(bus.row_idx), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_cpsel", int'(bus.cp_sram_sel), 0);
            reset = 1'b0;
            bus.cp_done = 1'b1;
            bus.ld_done = 1'b1;
            tick();
            bus.cp_done = 1'b0;
            bus.ld_done = 1'b0;
            repeat (3) tick();
            check("abort_idle", int'(bus.mast_curr_state), 0);
            check("abort_busy", int'(bus.busy), 0);
            check("abort_cp", int'(bus.cp_start), 0);
        end else begin
            check("finished", int'(fin), 1);
            check("cp_count", n_cp, v.exp_cp);
            check("ld_count", n_ld, v.exp_ld);
            bus.ld_done = 1'b0;
            bus.cp_done = 1'b0;
            repeat (2) begin
                tick();
                if (bus.sched_done) n_done++;
            end
            check("done_count", n_done, 1);
        end
        bus.start_reg = 1'b0;
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        bus.start_reg    = 1'b0;
        bus.cfg_tile_num = '0;
        bus.cfg_row_num  = '0;
        bus.ld_done      = 1'b0;
        bus.cp_done      = 1'b0;

        tbl[0] = '{1, 1, 4, -1, 1'b0, 1, 1};
        tbl[1] = '{4, 2, 0, -1, 1'b0, 8, 8};
        tbl[2] = '{4, 2, 1, -1, 1'b0, 8, 8};
        tbl[3] = '{4, 2, 2, -1, 1'b0, 8, 8};
        tbl[4] = '{4, 2, 3, -1, 1'b0, 8, 8};
        tbl[5] = '{3, 2, 0, -1, 1'b1, 6, 6};
        tbl[6] = '{2, 3, 3, -1, 1'b0, 6, 6};
        tbl[7] = '{4, 2, 0, 6, 1'b0, 0, 0};

        repeat (3) tick();
        check("reset_state", int'(bus.mast_curr_state), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_tile", int'(bus.tile_idx), 0);
        check("reset_row", int'(bus.row_idx), 0);
        check("reset_sels", int'({bus.cp_sram_sel, bus.ld_sram_sel}), 0);
        check("reset_pads", int'({bus.pad_lf, bus.pad_rg}), 0);
        check("reset_pulses",
              int'({bus.ld_start, bus.cp_start, bus.sched_done}), 0);
        reset = 1'b0;
        tick();

        bus.cfg_tile_num = 10'd0;
        bus.cfg_row_num  = 10'd3;
        bus.start_reg    = 1'b1;
        tick();
        bus.start_reg = 1'b0;
        tick();
        check("zero_tile_state", int'(bus.mast_curr_state), 0);
        check("zero_tile_busy", int'(bus.busy), 0);
        bus.cfg_tile_num = 10'd2;
        bus.cfg_row_num  = 10'd0;
        bus.start_reg    = 1'b1;
        tick();
        bus.start_reg = 1'b0;
        tick();
        check("zero_row_state", int'(bus.mast_curr_state), 0);

        // Done pulses coinciding with their start pulse must be dropped.
        bus.cfg_tile_num = 10'd1;
        bus.cfg_row_num  = 10'd1;
        bus.start_reg    = 1'b1;
        tick();
        bus.start_reg = 1'b0;
        check("drop_fsld_ld", int'(bus.ld_start), 1);
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        repeat (2) tick();
        check("drop_fsld_hold", int'(bus.mast_curr_state), 7);
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        check("drop_left", int'(bus.mast_curr_state), 1);
        check("drop_cp", int'(bus.cp_start), 1);
        check("drop_pads", int'({bus.pad_lf, bus.pad_rg}), 3);
        check("drop_no_ld", int'(bus.ld_start), 0);
        bus.cp_done = 1'b1;
        tick();
        bus.cp_done = 1'b0;
        repeat (2) tick();
        check("drop_tile_hold", int'(bus.mast_curr_state), 1);
        bus.cp_done = 1'b1;
        tick();
        bus.cp_done = 1'b0;
        check("drop_done", int'(bus.sched_done), 1);
        check("drop_idle", int'(bus.mast_curr_state), 0);
        tick();
        check("drop_done_once", int'(bus.sched_done), 0);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i]);
            tick();
        end

        for (int i = 0; i < 4; i++) begin
            rv.t       = int'($urandom_range(1, 6));
            rv.r       = int'($urandom_range(1, 3));
            rv.mode    = 0;
            rv.abort_k = -1;
            rv.mut     = 1'b0;
            rv.exp_cp  = rv.t * rv.r;
            rv.exp_ld  = rv.t * rv.r;
            run(rv);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
